// File: rtl/clock_mode_ctrl.sv
// -----------------------------------------------------------------------------
// clock_mode_ctrl
// Top-level mode controller for the digital clock. Conditions the four raw
// front-panel buttons (sync + debounce + rising-edge pulse), then sequences the
// shared HH:MM digit setter between editing the current time and the alarm.
//
// Ports:
//   clk, rst        system clock, asynchronous active-low reset
//   tick_1hz        one-cycle pulse per second
//   btn_*_raw       raw asynchronous active-high buttons (set, alarm, mode, inc)
//   ack_in          setter reports all four digits stepped through
//   edit_en         setter enable (high in SET_TIME / SET_ALARM)
//   edit_mode/inc   one-cycle forwarded mode / increment pulses to the setter
//   edit_target     0 = time, 1 = alarm; held until the next edit entry
//   time_load       one-cycle strobe: load setter digits into timekeeper
//   alarm_load      one-cycle strobe: load setter digits into alarm register
//   abort           one-cycle pulse on cancel or timeout
//   digit_sel       digit being edited (0 = hours tens .. 3 = minutes units)
//   blink           display blink phase for the selected digit
//   state           FSM state (RUN=0, SET_TIME=1, SET_ALARM=2, COMMIT=3)
// -----------------------------------------------------------------------------
module clock_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_SEC     = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_set_raw,
    input  logic       btn_alarm_raw,
    input  logic       btn_mode_raw,
    input  logic       btn_inc_raw,
    input  logic       ack_in,
    output logic       edit_en,
    output logic       edit_mode,
    output logic       edit_inc,
    output logic       edit_target,
    output logic       time_load,
    output logic       alarm_load,
    output logic       abort,
    output logic [1:0] digit_sel,
    output logic       blink,
    output logic [1:0] state
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_SEC + 1);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_SET_TIME  = 2'd1,
        ST_SET_ALARM = 2'd2,
        ST_COMMIT    = 2'd3
    } state_t;

    // Button index: 0 = set, 1 = alarm, 2 = mode, 3 = inc
    logic [3:0] btn_raw;
    logic [3:0] btn_pulse;

    assign btn_raw = {btn_inc_raw, btn_mode_raw, btn_alarm_raw, btn_set_raw};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            logic          meta_reg;
            logic          sync_reg;
            logic          level_reg;
            logic          pulse_reg;
            logic [DW-1:0] cnt_reg;
            logic          flip;

            // The level flips on the sample that would bring the count to
            // DEBOUNCE_CYCLES, so the edge pulse is registered on that same
            // clock and appears one cycle after the level decision.
            assign flip = (sync_reg != level_reg) &&
                          (cnt_reg == DW'(DEBOUNCE_CYCLES - 1));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    meta_reg  <= 1'b0;
                    sync_reg  <= 1'b0;
                    level_reg <= 1'b0;
                    pulse_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    meta_reg <= btn_raw[gi];
                    sync_reg <= meta_reg;
                    if (sync_reg == level_reg) begin
                        cnt_reg <= '0;
                    end else if (flip) begin
                        cnt_reg   <= '0;
                        level_reg <= ~level_reg;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                    pulse_reg <= flip & ~level_reg;
                end
            end

            assign btn_pulse[gi] = pulse_reg;
        end
    endgenerate

    logic set_p, alarm_p, mode_p, inc_p;
    assign set_p   = btn_pulse[0];
    assign alarm_p = btn_pulse[1];
    assign mode_p  = btn_pulse[2];
    assign inc_p   = btn_pulse[3];

    state_t        state_reg, state_next;
    logic [1:0]    digit_sel_reg, digit_sel_next;
    logic          blink_reg, blink_next;
    logic [TW-1:0] tmo_reg, tmo_next;
    logic          target_reg, target_next;
    logic          mode_reg, mode_next;
    logic          inc_reg, inc_next;
    logic          abort_reg, abort_next;

    logic own_pulse;
    logic edit_evt;
    logic timeout;

    // Cancel uses the same button that opened the edit; the other one is ignored.
    assign own_pulse = (state_reg == ST_SET_TIME) ? set_p : alarm_p;
    assign edit_evt  = mode_p | inc_p;
    // An edit pulse in the same cycle as the tick clears the count instead.
    assign timeout   = tick_1hz & ~edit_evt & (tmo_reg == TW'(TIMEOUT_SEC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_RUN;
            digit_sel_reg <= 2'd0;
            blink_reg     <= 1'b0;
            tmo_reg       <= '0;
            target_reg    <= 1'b0;
            mode_reg      <= 1'b0;
            inc_reg       <= 1'b0;
            abort_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            digit_sel_reg <= digit_sel_next;
            blink_reg     <= blink_next;
            tmo_reg       <= tmo_next;
            target_reg    <= target_next;
            mode_reg      <= mode_next;
            inc_reg       <= inc_next;
            abort_reg     <= abort_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        digit_sel_next = digit_sel_reg;
        blink_next     = blink_reg;
        tmo_next       = tmo_reg;
        target_next    = target_reg;
        mode_next      = 1'b0;
        inc_next       = 1'b0;
        abort_next     = 1'b0;

        case (state_reg)
            ST_RUN: begin
                digit_sel_next = 2'd0;
                blink_next     = 1'b0;
                tmo_next       = '0;
                if (set_p) begin
                    state_next  = ST_SET_TIME;
                    target_next = 1'b0;
                    blink_next  = 1'b1;
                end else if (alarm_p) begin
                    state_next  = ST_SET_ALARM;
                    target_next = 1'b1;
                    blink_next  = 1'b1;
                end
            end

            ST_SET_TIME, ST_SET_ALARM: begin
                if (ack_in) begin
                    state_next = ST_COMMIT;
                end else if (own_pulse || timeout) begin
                    state_next = ST_RUN;
                    abort_next = 1'b1;
                end else begin
                    mode_next = mode_p;
                    inc_next  = inc_p;
                    if (mode_p && (digit_sel_reg != 2'd3)) begin
                        digit_sel_next = digit_sel_reg + 2'd1;
                    end
                    if (edit_evt) begin
                        tmo_next = '0;
                    end else if (tick_1hz) begin
                        tmo_next = tmo_reg + 1'b1;
                    end
                    if (tick_1hz) begin
                        blink_next = ~blink_reg;
                    end
                end
                if (state_next != state_reg) begin
                    digit_sel_next = 2'd0;
                    blink_next     = 1'b0;
                    tmo_next       = '0;
                end
            end

            default: begin  // ST_COMMIT: single cycle, back to RUN
                state_next     = ST_RUN;
                digit_sel_next = 2'd0;
                blink_next     = 1'b0;
                tmo_next       = '0;
            end
        endcase
    end

    assign edit_en     = (state_reg == ST_SET_TIME) || (state_reg == ST_SET_ALARM);
    assign edit_mode   = mode_reg;
    assign edit_inc    = inc_reg;
    assign edit_target = target_reg;
    assign time_load   = (state_reg == ST_COMMIT) && !target_reg;
    assign alarm_load  = (state_reg == ST_COMMIT) && target_reg;
    assign abort       = abort_reg;
    assign digit_sel   = digit_sel_reg;
    assign blink       = blink_reg;
    assign state       = state_reg;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_mode_ctrl
// Directed bench for clock_mode_ctrl with a small model of the digit setter
// (acks after four forwarded mode pulses while enabled).
// -----------------------------------------------------------------------------
module tb_clock_mode_ctrl;

    localparam int DEB = 4;
    localparam int TMO = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] btn = 4'b0000;   // 0 set, 1 alarm, 2 mode, 3 inc
    logic       ack_force = 1'b0;
    logic       ack_in;

    logic       edit_en, edit_mode, edit_inc, edit_target;
    logic       time_load, alarm_load, abort, blink;
    logic [1:0] digit_sel, state;

    int checks = 0;
    int errors = 0;

    int n_tl = 0, n_al = 0, n_ab = 0, n_mode = 0, n_inc = 0;

    always #5 clk = ~clk;

    clock_mode_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_SEC    (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_1hz     (tick),
        .btn_set_raw  (btn[0]),
        .btn_alarm_raw(btn[1]),
        .btn_mode_raw (btn[2]),
        .btn_inc_raw  (btn[3]),
        .ack_in       (ack_in),
        .edit_en      (edit_en),
        .edit_mode    (edit_mode),
        .edit_inc     (edit_inc),
        .edit_target  (edit_target),
        .time_load    (time_load),
        .alarm_load   (alarm_load),
        .abort        (abort),
        .digit_sel    (digit_sel),
        .blink        (blink),
        .state        (state)
    );

    // Setter model: steps through four digits on edit_mode, acks after the 4th.
    logic [2:0] m_cnt;
    always @(posedge clk or negedge rst) begin
        if (!rst)                           m_cnt <= 3'd0;
        else if (!edit_en)                  m_cnt <= 3'd0;
        else if (edit_mode && m_cnt != 3'd4) m_cnt <= m_cnt + 3'd1;
    end
    assign ack_in = ack_force | (m_cnt == 3'd4);

    // Pulse counters; a stretched pulse counts more than once.
    always @(negedge clk) begin
        if (time_load)  n_tl++;
        if (alarm_load) n_al++;
        if (abort)      n_ab++;
        if (edit_mode)  n_mode++;
        if (edit_inc)   n_inc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic press(input int id);
        @(negedge clk);
        btn[id] = 1'b1;
        repeat (8) @(negedge clk);
        btn[id] = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic tick_once();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick_once();
    endtask

    int b_tl, b_al, b_ab, b_mode, b_inc;
    int hits, hit_at;

    task automatic snap();
        b_tl = n_tl; b_al = n_al; b_ab = n_ab; b_mode = n_mode; b_inc = n_inc;
    endtask

    initial begin
        // ---------------- reset state ----------------
        #1;
        check("reset_outputs", {20'd0, edit_en, edit_mode, edit_inc, edit_target, time_load,
                                alarm_load, abort, blink, digit_sel, state}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // ---------------- enter SET_TIME ----------------
        press(0);
        check("set_state", state, 1);
        check("set_edit_en", edit_en, 1);
        check("set_digit_sel", digit_sel, 0);
        check("set_target", edit_target, 0);
        check("set_blink", blink, 1);

        // ---------------- debounce: 3-cycle glitch ----------------
        snap();
        @(negedge clk);
        btn[3] = 1'b1;
        repeat (3) @(negedge clk);
        btn[3] = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_no_inc", n_inc - b_inc, 0);

        // ---------------- debounce: held 20 cycles ----------------
        hits = 0; hit_at = -1;
        @(negedge clk);
        btn[3] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (edit_inc) begin
                hits++;
                hit_at = k;
            end
        end
        btn[3] = 1'b0;
        repeat (10) @(negedge clk);
        check("held_inc_count", hits, 1);
        check("held_inc_cycle", hit_at, DEB + 2);
        check("held_inc_total", n_inc - b_inc, 1);

        // ---------------- full time edit ----------------
        snap();
        for (int i = 1; i <= 3; i++) begin
            press(2);
            check("time_digit_sel", digit_sel, i);
        end
        press(2);
        check("time_commit_state", state, 0);
        check("time_load_pulses", n_tl - b_tl, 1);
        check("time_alarm_load", n_al - b_al, 0);
        check("time_abort", n_ab - b_ab, 0);
        check("time_mode_fwd", n_mode - b_mode, 4);
        check("time_target", edit_target, 0);

        // ---------------- alarm edit ----------------
        snap();
        press(1);
        check("alarm_state", state, 2);
        check("alarm_target", edit_target, 1);
        check("alarm_edit_en", edit_en, 1);
        repeat (4) press(2);
        check("alarm_commit_state", state, 0);
        check("alarm_load_pulses", n_al - b_al, 1);
        check("alarm_time_load", n_tl - b_tl, 0);
        check("alarm_target_held", edit_target, 1);

        // ---------------- timeout ----------------
        snap();
        press(0);
        check("tmo_enter", state, 1);
        ticks(TMO - 1);
        check("tmo_29_state", state, 1);
        check("tmo_29_blink", blink, 0);
        press(3);
        ticks(TMO - 1);
        check("tmo_after_inc_29", state, 1);
        check("tmo_no_abort_yet", n_ab - b_ab, 0);
        tick_once();
        repeat (2) @(negedge clk);
        check("tmo_fire_state", state, 0);
        check("tmo_abort", n_ab - b_ab, 1);
        check("tmo_no_load", (n_tl - b_tl) + (n_al - b_al), 0);

        // ---------------- edit pulse and tick in same cycle ----------------
        snap();
        press(0);
        ticks(TMO - 1);
        @(negedge clk);
        btn[3] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == DEB + 1) tick = 1'b1;
            if (k == DEB + 2) tick = 1'b0;
        end
        btn[3] = 1'b0;
        repeat (8) @(negedge clk);
        check("same_cycle_state", state, 1);
        ticks(TMO - 1);
        check("same_cycle_29", state, 1);
        tick_once();
        repeat (2) @(negedge clk);
        check("same_cycle_fire", state, 0);
        check("same_cycle_abort", n_ab - b_ab, 1);

        // ---------------- priorities ----------------
        snap();
        @(negedge clk);
        btn[0] = 1'b1;
        btn[1] = 1'b1;
        repeat (8) @(negedge clk);
        btn[0] = 1'b0;
        btn[1] = 1'b0;
        repeat (8) @(negedge clk);
        check("both_state", state, 1);
        check("both_target", edit_target, 0);
        press(1);
        check("cross_ignored", state, 1);
        press(0);
        check("cancel_state", state, 0);
        check("cancel_abort", n_ab - b_ab, 1);
        check("cancel_no_load", n_tl - b_tl, 0);

        snap();
        press(0);
        @(negedge clk);
        btn[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == DEB + 1) ack_force = 1'b1;
            if (k == DEB + 2) ack_force = 1'b0;
        end
        btn[0] = 1'b0;
        repeat (8) @(negedge clk);
        check("ack_cancel_state", state, 0);
        check("ack_cancel_load", n_tl - b_tl, 1);
        check("ack_cancel_abort", n_ab - b_ab, 0);

        // ---------------- async reset mid-edit ----------------
        press(1);
        check("rst_pre_state", state, 2);
        check("rst_pre_blink", blink, 1);
        snap();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_async_outputs", {20'd0, edit_en, edit_mode, edit_inc, edit_target, time_load,
                                    alarm_load, abort, blink, digit_sel, state}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_post_state", state, 0);
        check("rst_post_strobes", (n_tl - b_tl) + (n_al - b_al) + (n_ab - b_ab), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_mode_ctrl.md
Name: clock_mode_ctrl

Overview:
- Top-level mode controller for the digital clock.
- Debounces and edge-detects the raw front-panel buttons.
- Sequences the shared digit-setter datapath (HH:MM editor with enable, mode/inc inputs and ack output) between two requesters: current time and alarm time.
- Issues one-cycle load strobes to the timekeeping counter or the alarm register, and provides edit timeout, digit-select and blink outputs for the display.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required to change a debounced button level (≥2).
- TIMEOUT_SEC, 30: tick_1hz pulses without an accepted edit pulse before the edit is aborted (≥2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- tick_1hz  in  1  one-cycle pulse per second, synchronous to clk
- btn_set_raw  in  1  raw set-time button, asynchronous, active-high
- btn_alarm_raw  in  1  raw set-alarm button, asynchronous, active-high
- btn_mode_raw  in  1  raw next-digit button, asynchronous, active-high
- btn_inc_raw  in  1  raw increment button, asynchronous, active-high
- ack_in  in  1  setter ack (high when all four digits have been stepped through)
- edit_en  out  1  setter enable
- edit_mode  out  1  one-cycle mode pulse to setter
- edit_inc  out  1  one-cycle increment pulse to setter
- edit_target  out  1  0 = time, 1 = alarm; steers setter outputs
- time_load  out  1  one-cycle strobe: load setter digits into timekeeper
- alarm_load  out  1  one-cycle strobe: load setter digits into alarm register
- abort  out  1  one-cycle pulse on cancel or timeout
- digit_sel  out  2  digit being edited: 0 = hours tens … 3 = minutes units
- blink  out  1  display blink phase for the selected digit
- state  out  2  FSM state encoding, for debug

Behaviour:
- Reset (rst low, asynchronous):
  - state = RUN; all synchronizer, debounce and timer registers cleared.
  - All outputs 0, including edit_target = 0.
- Button front end (identical for each button):
  - Two-flop synchronizer, then a debounce counter.
  - The counter increments while the synchronized value differs from the debounced level and clears when they are equal.
  - On reaching DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A registered rising-edge pulse follows the debounced level.
  - Latency: raw first sampled high at edge E0 → pulse high for exactly the cycle between edges E0+DEBOUNCE_CYCLES+1 and E0+DEBOUNCE_CYCLES+2.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse. A held button produces one pulse only; there is no auto-repeat.
- FSM states: RUN = 0, SET_TIME = 1, SET_ALARM = 2, COMMIT = 3.
- RUN:
  - set pulse → SET_TIME, edit_target = 0.
  - alarm pulse → SET_ALARM, edit_target = 1.
  - Both in the same cycle: SET_TIME wins.
  - mode and inc pulses are discarded.
- On entry to SET_TIME or SET_ALARM:
  - edit_en = 1 from the first cycle of the state; digit_sel = 0; blink = 1; timeout counter = 0.
- In SET_TIME / SET_ALARM, events are checked in priority order:
  1. ack_in = 1 → COMMIT.
  2. A set pulse in SET_TIME, or an alarm pulse in SET_ALARM → cancel: RUN, abort = 1 for one cycle, no load.
  3. Timeout → RUN, abort = 1 for one cycle, no load.
- Cross-button in an edit state: an alarm pulse in SET_TIME, or a set pulse in SET_ALARM, is ignored.
- Forwarding: debounced mode and inc pulses are copied to edit_mode / edit_inc in the following cycle (registered), only while in an edit state and only when no transition is taken that cycle.
- digit_sel increments on each forwarded mode pulse and saturates at 3.
- Timeout counter (edit states only):
  - Clears on each forwarded mode or inc pulse; increments on tick_1hz.
  - Timeout fires on a tick_1hz arriving with counter = TIMEOUT_SEC-1.
  - An edit pulse and a tick in the same cycle: the clear wins.
- blink toggles on each tick_1hz in edit states; blink = 0 in RUN and COMMIT.
- COMMIT (lasts exactly one cycle):
  - edit_en = 0, so the setter returns to its first digit.
  - time_load = 1 if edit_target = 0, else alarm_load = 1.
  - Next state RUN.
  - edit_target holds its value through COMMIT and RUN until the next edit entry.
- The setter's digit registers are not cleared by the controller. The next edit session starts from the last edited values.
- Reset mid-edit: immediate return to RUN, no load strobe, no abort pulse.

Test Plan:
- Debounce: btn_inc_raw high for 3 cycles, then 0, in SET_TIME → no edit_inc. Then held 20 cycles → exactly one edit_inc, at E0+DEBOUNCE_CYCLES+2.
- Full time edit: set press → state = 1, edit_en = 1, digit_sel = 0. Four mode presses with a model setter asserting ack_in → digit_sel 0→1→2→3, then COMMIT with time_load = 1 for one cycle, alarm_load = 0, state returns to 0.
- Alarm edit: alarm press → edit_target = 1. Complete sequence → alarm_load pulse only; edit_target still 1 in RUN.
- Timeout: enter SET_TIME, give 29 ticks, inc press, then 30 ticks → abort on the 30th tick after the inc, no load, state = 0. Edit pulse and tick in the same cycle resets the count.
- Priorities: set and alarm pulses in the same cycle in RUN → SET_TIME. ack_in coinciding with a cancel press → COMMIT with time_load, no abort.
- Async reset asserted in SET_ALARM with blink = 1 → all outputs 0 immediately, state = RUN, and no load strobe after rst is released.
